// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Refill FSM states and the byte-lane insert used while assembling a line.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LAST
    } state_e;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned BYTE_BITS = 8;

    // Byte k of a little-endian word occupies bits [8k+7:8k].
    function automatic logic [WORD_BITS-1:0] put_byte(input logic [WORD_BITS-1:0] word,
                                                      input logic [1:0]           lane,
                                                      input logic [BYTE_BITS-1:0] value);
        logic [WORD_BITS-1:0] res;
        res = word;
        res[BYTE_BITS*lane +: BYTE_BITS] = value;
        return res;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The cache takes the slave view; the surrounding pipeline/bench takes master.
interface icache_if #(
    parameter int unsigned ADDR_WIDTH = 18
) ();

    logic                  req_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  inst_valid_out;
    logic [31:0]           inst_out;
    logic                  mem_busy_in;
    logic                  mc_req_out;
    logic [ADDR_WIDTH-1:0] mc_addr_out;
    logic [7:0]            mc_data_in;

    modport slave (
        input  req_in, addr_in, mem_busy_in, mc_data_in,
        output inst_valid_out, inst_out, mc_req_out, mc_addr_out
    );

    modport master (
        output req_in, addr_in, mem_busy_in, mc_data_in,
        input  inst_valid_out, inst_out, mc_req_out, mc_addr_out
    );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the cache: combinational read port, one write port.
// Only valid bits are reset; tag/data are qualified by valid.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 7,
    parameter int unsigned TAG_BITS   = 9
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [WORD_BITS-1:0]  rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [WORD_BITS-1:0]  wr_data_i
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [WORD_BITS-1:0] data_q [LINES];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_valid_o = valid_q[rd_idx_i];
        rd_tag_o   = tag_q[rd_idx_i];
        rd_data_o  = data_q[rd_idx_i];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with a four-byte refill FSM.
// Hits answer combinationally; the memory-controller port yields to MEM on busy.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 7,
    parameter int unsigned ADDR_WIDTH = 18
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    icache_if.slave   bus
);

    localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [WORD_BITS-1:0]  buf_q, buf_d;

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0]   rd_tag_req;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [WORD_BITS-1:0]  rd_data;
    logic                  hit;
    logic                  we;
    logic [WORD_BITS-1:0]  wr_data;

    assign rd_idx     = bus.addr_in[INDEX_BITS+1:2];
    assign rd_tag_req = bus.addr_in[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit        = bus.req_in && !bus.mem_busy_in && (state_q == IDLE)
                        && rd_valid && (rd_tag == rd_tag_req);

    // Byte 3 arrives in LAST and goes straight into the written word.
    assign we      = rdy_in && (state_q == LAST) && !bus.mem_busy_in;
    assign wr_data = put_byte(buf_q, 2'd3, bus.mc_data_in);

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (we),
        .wr_idx_i   (fill_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (fill_addr_q[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_data_i  (wr_data)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_addr_q <= '0;
            buf_q       <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_addr_q <= fill_addr_d;
            buf_q       <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_addr_d = fill_addr_q;
        buf_d       = buf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_in && !hit && !bus.mem_busy_in) begin
                    state_d     = FILL;
                    fill_addr_d = bus.addr_in & ~ADDR_WIDTH'(3);
                    cnt_d       = '0;
                    buf_d       = '0;
                end
            end
            FILL: begin
                if (bus.mem_busy_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    buf_d   = '0;
                end else begin
                    // Data on mc_data_in belongs to the byte issued one cycle earlier.
                    if (cnt_q != 2'd0) begin
                        buf_d = put_byte(buf_q, cnt_q - 2'd1, bus.mc_data_in);
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                state_d = IDLE;
                cnt_d   = '0;
                buf_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.inst_valid_out = hit;
        bus.inst_out       = hit ? rd_data : '0;
        bus.mc_req_out     = rdy_in && (state_q == FILL) && !bus.mem_busy_in;
        bus.mc_addr_out    = (state_q == FILL) ? (fill_addr_q | ADDR_WIDTH'(cnt_q)) : '0;
    end

endmodule

// File: tb/tb_icache.sv
// Randomized and directed bench for icache against a transaction-level model:
// the model tracks which word address each line holds and a refill step number.
module tb_icache;

    localparam int AW    = 18;
    localparam int IB    = 7;
    localparam int LINES = 1 << IB;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk_in = ~clk_in;

    icache_if #(.ADDR_WIDTH(AW)) bus ();

    icache #(
        .INDEX_BITS (IB),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    // Byte memory behind the controller: one-cycle read latency, frozen while rdy_in is low.
    logic [7:0] mem [0:(1<<AW)-1];

    always @(posedge clk_in) begin
        if (rdy_in && bus.mc_req_out) begin
            bus.mc_data_in <= mem[bus.mc_addr_out];
        end
    end

    int checks = 0;
    int errors = 0;

    int m_line [LINES];
    int step;
    int base;
    logic [31:0] last_inst;
    logic        last_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memword(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < LINES; i++) m_line[i] = -1;
        step = -1;
        base = 0;
    endfunction

    task automatic do_reset(input int hold_cycles);
        @(negedge clk_in);
        rst_in         = 1'b1;
        bus.req_in     = 1'b0;
        bus.mem_busy_in = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(bus.inst_valid_out), 32'd0);
        chk("rst_inst",  bus.inst_out,            32'd0);
        chk("rst_mcreq", 32'(bus.mc_req_out),     32'd0);
        chk("rst_mcaddr", 32'(bus.mc_addr_out),   32'd0);
        repeat (hold_cycles) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic cycle(input bit req, input int addr, input bit busy, input bit rdy);
        bit   filling, exp_hit, exp_req;
        int   wa, idx, exp_addr;
        logic [31:0] exp_inst;
        @(negedge clk_in);
        bus.req_in      = req;
        bus.addr_in     = AW'(addr);
        bus.mem_busy_in = busy;
        rdy_in          = rdy;
        #1;
        filling  = (step >= 0);
        wa       = addr & ~3;
        idx      = (addr >> 2) % LINES;
        exp_hit  = !filling && req && !busy && (m_line[idx] == wa);
        exp_inst = exp_hit ? memword(wa) : 32'd0;
        exp_req  = filling && (step <= 3) && rdy && !busy;
        exp_addr = (filling && step <= 3) ? base + step : 0;
        chk("inst_valid", 32'(bus.inst_valid_out), 32'(exp_hit));
        chk("inst",       bus.inst_out,            exp_inst);
        chk("mc_req",     32'(bus.mc_req_out),     32'(exp_req));
        chk("mc_addr",    32'(bus.mc_addr_out),    32'(exp_addr));
        last_inst  = bus.inst_out;
        last_valid = bus.inst_valid_out;
        @(posedge clk_in);
        if (rdy) begin
            if (filling) begin
                if (busy) begin
                    step = -1;
                end else if (step == 4) begin
                    m_line[(base >> 2) % LINES] = base;
                    step = -1;
                end else begin
                    step++;
                end
            end else if (req && !exp_hit && !busy) begin
                step = 0;
                base = wa;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mem[16'h10] = 8'h13;
        mem[16'h11] = 8'h05;
        mem[16'h12] = 8'h00;
        mem[16'h13] = 8'h00;
        rdy_in          = 1'b1;
        rst_in          = 1'b0;
        bus.req_in      = 1'b0;
        bus.addr_in     = '0;
        bus.mem_busy_in = 1'b0;
        model_reset();
        do_reset(2);

        // First miss on 0x10: six cycles of refill, answered in T+6.
        for (int i = 0; i < 7; i++) cycle(1'b1, 'h10, 1'b0, 1'b1);
        chk("t1_valid", 32'(last_valid), 32'd1);
        chk("t1_inst",  last_inst,       32'h0000_0513);

        cycle(1'b1, 'h10, 1'b0, 1'b1);
        chk("rehit", 32'(last_valid), 32'd1);

        // Conflicting tag on the same index evicts 0x10.
        for (int i = 0; i < 7; i++) cycle(1'b1, 'h210, 1'b0, 1'b1);
        cycle(1'b1, 'h10, 1'b0, 1'b1);
        chk("evicted", 32'(last_valid), 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 'h10, 1'b0, 1'b1);

        // MEM steals the port at T+3, refill restarts from byte 0.
        for (int i = 0; i < 3; i++) cycle(1'b1, 'h40, 1'b0, 1'b1);
        cycle(1'b1, 'h40, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 'h40, 1'b0, 1'b1);

        // Request dropped at T+2 still completes the line.
        for (int i = 0; i < 2; i++) cycle(1'b1, 'h80, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 'h1234, 1'b0, 1'b1);
        cycle(1'b1, 'h80, 1'b0, 1'b1);
        chk("drop_hit", 32'(last_valid), 32'd1);

        // rdy_in low for three cycles mid-refill.
        for (int i = 0; i < 3; i++) cycle(1'b1, 'hC0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 'hC0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 'hC0, 1'b0, 1'b1);
        chk("rdy_hit", 32'(last_valid), 32'd1);

        // Random traffic over a small set of tags/indices to force hits and conflicts.
        for (int n = 0; n < 3000; n++) begin
            int a;
            a = (int'($urandom_range(0, 3)) << (IB + 2)) | (int'($urandom_range(0, 7)) << 2)
                | int'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1);
            end else begin
                cycle($urandom_range(0, 9) < 8, a, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
